keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream input stage for the `calculator` block.
- Scans a 4x4 matrix keypad, synchronises and debounces the column inputs, and encodes each debounced key press.
- Each press produces either a BCD digit on `bcdInput` with a one-cycle `DigitValid` strobe, or a one-cycle `Enter`/`Plus`/`Minus`/`Equals`/`Clear` pulse. These outputs drive the calculator's inputs of the same names.

Parameters:
- SCAN_DIV, 1000: Clock cycles per scan tick. Legal range is 4 or more.
- DEBOUNCE, 4: consecutive matching ticks required to accept a press, and also to accept a release. Legal range is 1 to 15.

Ports:
- Clock  in  1  system clock. All logic is on the rising edge.
- ResetN  in  1  synchronous, active-low reset.
- Col  in  4  keypad columns, active-low (pulled up externally). Asynchronous to Clock.
- Row  out  4  keypad row drive, one-hot active-low.
- bcdInput  out  4  last accepted digit, BCD 0-9.
- DigitValid  out  1  one-cycle strobe. Asserted when `bcdInput` is updated.
- Enter, Plus, Minus, Equals, Clear  out  1 each  one-cycle function-key pulses.

Behaviour:
- Col synchroniser: two flops. The sampled value is `colS`.
- Tick counter:
  - Counts 0 to SCAN_DIV-1, free-running.
  - `tick` is asserted when count equals SCAN_DIV-1.
- Key map (row r = Row[r] low; column c = Col[c] low):
  - r0: 1, 2, 3, Plus
  - r1: 4, 5, 6, Minus
  - r2: 7, 8, 9, Clear
  - r3: Enter, 0, Equals, unused
- "Single key" means exactly one bit of `colS` is 0. Zero or two-or-more low bits count as no key.
- FSM states: SCAN, DEBOUNCE, HELD. All transitions happen only on `tick`.
- SCAN:
  - Single key: latch (row, col), set `stableCnt` = 1. If DEBOUNCE = 1, accept immediately; otherwise go to DEBOUNCE. Row is not advanced.
  - Otherwise: rotate Row to the next row (r3 wraps to r0).
- DEBOUNCE:
  - Same single column: `stableCnt` increments. When it reaches DEBOUNCE, accept the key and go to HELD.
  - Anything else: go to SCAN and advance Row.
- Accept:
  - In the Clock cycle after the accepting tick, assert exactly one output for exactly one cycle.
  - Digit key: `bcdInput` is loaded in that same cycle and `DigitValid` = 1.
  - Function key: the matching pulse = 1 and `bcdInput` is unchanged.
  - Unused key: no output, but the FSM still goes to HELD.
- HELD:
  - Row stays frozen.
  - On each tick, `colS` = 4'b1111 increments `relCnt`; any other value clears it to 0.
  - When `relCnt` reaches DEBOUNCE: go to SCAN, advance Row, clear both counters.
  - No auto-repeat. A second key pressed while in HELD is ignored until full release.
- Outputs are registered. Pulses never overlap. `bcdInput` never takes a value above 9.
- Reset (ResetN = 0 at a Clock edge, in any state including mid-HELD):
  - Row = 4'b1110, `bcdInput` = 0, all strobes/pulses = 0.
  - State = SCAN, tick counter, `stableCnt` and `relCnt` = 0, synchroniser = 4'b1111.
  - Reset takes priority over `tick`.
- Press latency: the press must be visible in `colS` on DEBOUNCE consecutive ticks while its row is driven. The strobe follows 1 cycle after the last of those ticks.

Test Plan:
Bench settings: SCAN_DIV = 4, DEBOUNCE = 3. The keypad model drives Col[c] low only while the pressed key's Row[r] is low.
- Reset: hold ResetN = 0 for 2 cycles -> Row = 1110, `bcdInput` = 0000, all pulses 0. After release, Row steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 cycles.
- Press '5' (r1, c1) and hold 200 cycles -> exactly one `DigitValid` pulse, `bcdInput` = 0101. Row stays at 1101 while held. Release -> after 3 clean ticks, scanning resumes.
- Bounce on '8': Col[1] toggles every tick during row r2 -> no output. FSM returns to SCAN and Row advances.
- After '5', press Minus (r1, c3) -> `Minus` high for exactly 1 cycle, `bcdInput` still 0101, `DigitValid` stays 0.
- Two keys in one row ('1' and '3', r0, c0 + c2) -> no pulse and Row keeps scanning. Unused key (r3, c3) -> no output, Row freezes until release.
- Press '9', then assert ResetN = 0 during HELD -> outputs cleared, Row = 1110. Release all keys, then press '0' -> `bcdInput` = 0000 with one `DigitValid` pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: synchronises and debounces the columns, then encodes
// each accepted press as a BCD digit strobe or a one-cycle function-key pulse.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic [3:0] bcdInput,
  output logic       DigitValid,
  output logic       Enter,
  output logic       Plus,
  output logic       Minus,
  output logic       Equals,
  output logic       Clear,
  output logic [1:0] state_dbg_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [3:0]    col_meta_q, col_s_q;
  logic [CW-1:0] div_q, div_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    row_oh_q, row_oh_d;
  logic [1:0]    key_row_q, key_row_d;
  logic [1:0]    key_col_q, key_col_d;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    rel_q, rel_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          dv_q, dv_d, ent_q, ent_d, plus_q, plus_d;
  logic          minus_q, minus_d, eq_q, eq_d, clr_q, clr_d;

  logic       tick;
  logic       single;
  logic [1:0] col_idx;
  logic [1:0] row_idx;
  logic       accept;
  logic [1:0] acc_row, acc_col;
  logic [3:0] row_next;

  assign tick     = (div_q == TICK_MAX);
  assign row_next = {row_oh_q[2:0], row_oh_q[3]};

  always_comb begin
    single  = 1'b0;
    col_idx = 2'd0;
    case (col_s_q)
      4'b1110: begin single = 1'b1; col_idx = 2'd0; end
      4'b1101: begin single = 1'b1; col_idx = 2'd1; end
      4'b1011: begin single = 1'b1; col_idx = 2'd2; end
      4'b0111: begin single = 1'b1; col_idx = 2'd3; end
      default: begin single = 1'b0; col_idx = 2'd0; end
    endcase
  end

  always_comb begin
    case (row_oh_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    state_d   = state_q;
    row_oh_d  = row_oh_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    stable_d  = stable_q;
    rel_d     = rel_q;
    accept    = 1'b0;
    acc_row   = key_row_q;
    acc_col   = key_col_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (single) begin
            key_row_d = row_idx;
            key_col_d = col_idx;
            stable_d  = 4'd1;
            if (DEB_N == 4'd1) begin
              accept  = 1'b1;
              acc_row = row_idx;
              acc_col = col_idx;
              state_d = ST_HELD;
            end else begin
              state_d = ST_DEB;
            end
          end else begin
            row_oh_d = row_next;
          end
        end
        ST_DEB: begin
          if (single && (col_idx == key_col_q)) begin
            stable_d = stable_q + 4'd1;
            if ((stable_q + 4'd1) == DEB_N) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end
          end else begin
            state_d  = ST_SCAN;
            row_oh_d = row_next;
            stable_d = 4'd0;
          end
        end
        ST_HELD: begin
          // Row stays frozen; only a run of all-high column ticks ends the hold.
          if (col_s_q == 4'b1111) begin
            if ((rel_q + 4'd1) == DEB_N) begin
              state_d  = ST_SCAN;
              row_oh_d = row_next;
              rel_d    = 4'd0;
              stable_d = 4'd0;
            end else begin
              rel_d = rel_q + 4'd1;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    bcd_d   = bcd_q;
    dv_d    = 1'b0;
    ent_d   = 1'b0;
    plus_d  = 1'b0;
    minus_d = 1'b0;
    eq_d    = 1'b0;
    clr_d   = 1'b0;
    if (accept) begin
      case ({acc_row, acc_col})
        4'h0: begin bcd_d = 4'd1; dv_d = 1'b1; end
        4'h1: begin bcd_d = 4'd2; dv_d = 1'b1; end
        4'h2: begin bcd_d = 4'd3; dv_d = 1'b1; end
        4'h3: plus_d = 1'b1;
        4'h4: begin bcd_d = 4'd4; dv_d = 1'b1; end
        4'h5: begin bcd_d = 4'd5; dv_d = 1'b1; end
        4'h6: begin bcd_d = 4'd6; dv_d = 1'b1; end
        4'h7: minus_d = 1'b1;
        4'h8: begin bcd_d = 4'd7; dv_d = 1'b1; end
        4'h9: begin bcd_d = 4'd8; dv_d = 1'b1; end
        4'hA: begin bcd_d = 4'd9; dv_d = 1'b1; end
        4'hB: clr_d = 1'b1;
        4'hC: ent_d = 1'b1;
        4'hD: begin bcd_d = 4'd0; dv_d = 1'b1; end
        4'hE: eq_d = 1'b1;
        default: bcd_d = bcd_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      col_meta_q <= 4'b1111;
      col_s_q    <= 4'b1111;
      div_q      <= '0;
      state_q    <= ST_SCAN;
      row_oh_q   <= 4'b1110;
      key_row_q  <= 2'd0;
      key_col_q  <= 2'd0;
      stable_q   <= 4'd0;
      rel_q      <= 4'd0;
      bcd_q      <= 4'd0;
      dv_q       <= 1'b0;
      ent_q      <= 1'b0;
      plus_q     <= 1'b0;
      minus_q    <= 1'b0;
      eq_q       <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      col_meta_q <= Col;
      col_s_q    <= col_meta_q;
      div_q      <= div_d;
      state_q    <= state_d;
      row_oh_q   <= row_oh_d;
      key_row_q  <= key_row_d;
      key_col_q  <= key_col_d;
      stable_q   <= stable_d;
      rel_q      <= rel_d;
      bcd_q      <= bcd_d;
      dv_q       <= dv_d;
      ent_q      <= ent_d;
      plus_q     <= plus_d;
      minus_q    <= minus_d;
      eq_q       <= eq_d;
      clr_q      <= clr_d;
    end
  end

  assign Row         = row_oh_q;
  assign bcdInput    = bcd_q;
  assign DigitValid  = dv_q;
  assign Enter       = ent_q;
  assign Plus        = plus_q;
  assign Minus       = minus_q;
  assign Equals      = eq_q;
  assign Clear       = clr_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives Col from Row and pressed keys,
// and every output pulse is logged as an event and compared with the key table.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] bcd;
  logic       dv, ent, pls, mns, eqs, clr;
  logic [1:0] st_dbg;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .Clock(clk), .ResetN(rst_n), .Col(col), .Row(row), .bcdInput(bcd),
    .DigitValid(dv), .Enter(ent), .Plus(pls), .Minus(mns), .Equals(eqs),
    .Clear(clr), .state_dbg_o(st_dbg)
  );

  // Event codes: 0-9 digit, 10 Enter, 11 Plus, 12 Minus, 13 Equals, 14 Clear, -1 none.
  int key_map [16] = '{1, 2, 3, 11, 4, 5, 6, 12, 7, 8, 9, 14, 10, 0, 13, -1};

  logic [15:0] press_mask = 16'h0;
  logic        bounce_en = 1'b0;
  logic        bounce_phase = 1'b0;
  int          bounce_div = 0;

  always @(negedge clk) begin
    if (bounce_div == 3) begin
      bounce_div   <= 0;
      bounce_phase <= ~bounce_phase;
    end else begin
      bounce_div <= bounce_div + 1;
    end
  end

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && !row[r]) col[c] = 1'b0;
    if (bounce_en && !row[2] && bounce_phase) col[1] = 1'b0;
  end

  logic [4:0] obs_q[$];
  logic [4:0] exp_q[$];
  int overlap_cnt = 0;
  int bcd_bad_cnt = 0;
  int checks = 0;
  int fails = 0;

  always @(negedge clk) begin
    int n;
    if (rst_n) begin
      n = int'(dv) + int'(ent) + int'(pls) + int'(mns) + int'(eqs) + int'(clr);
      if (n > 1) overlap_cnt++;
      if (bcd > 4'd9) bcd_bad_cnt++;
      if (dv)  obs_q.push_back(5'(bcd));
      if (ent) obs_q.push_back(5'd10);
      if (pls) obs_q.push_back(5'd11);
      if (mns) obs_q.push_back(5'd12);
      if (eqs) obs_q.push_back(5'd13);
      if (clr) obs_q.push_back(5'd14);
    end
  end

  task automatic test_reset();
    logic [3:0] exp_row;
    rst_n = 1'b0;
    press_mask = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (row !== 4'b1110) begin fails++; $display("FAIL reset_row got %b exp 1110", row); end
    checks++; if (bcd !== 4'd0) begin fails++; $display("FAIL reset_bcd got %h exp 0", bcd); end
    checks++; if ({dv, ent, pls, mns, eqs, clr} !== 6'b0) begin
      fails++; $display("FAIL reset_pulses got %b exp 000000", {dv, ent, pls, mns, eqs, clr});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      checks++; if (row !== exp_row) begin
        fails++; $display("FAIL scan_row cycle %0d got %b exp %b", k, row, exp_row);
      end
    end
  endtask

  task automatic test_press_5();
    int moved;
    int t;
    obs_q.delete();
    press_mask = 16'h1 << 5;
    moved = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k >= 50 && row !== 4'b1101) moved++;
    end
    checks++; if (obs_q.size() !== 1) begin fails++; $display("FAIL press5_count got %0d exp 1", obs_q.size()); end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== 5'd5) begin fails++; $display("FAIL press5_event got %0d exp 5", obs_q[0]); end
    checks++; if (bcd !== 4'd5) begin fails++; $display("FAIL press5_bcd got %h exp 5", bcd); end
    checks++; if (moved !== 0) begin fails++; $display("FAIL press5_row_frozen got %0d moves exp 0", moved); end
    press_mask = 16'h0;
    t = 0;
    while (row === 4'b1101 && t < 40) begin @(negedge clk); t++; end
    checks++; if (t >= 40) begin fails++; $display("FAIL press5_release timeout row %b", row); end
    checks++; if (row !== 4'b1011) begin fails++; $display("FAIL press5_resume got %b exp 1011", row); end
    checks++; if (obs_q.size() !== 1) begin fails++; $display("FAIL press5_no_repeat got %0d exp 1", obs_q.size()); end
  endtask

  task automatic test_bounce_8();
    int changes;
    logic [3:0] prev;
    obs_q.delete();
    bounce_en = 1'b1;
    changes = 0;
    prev = row;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (row !== prev) changes++;
      prev = row;
    end
    bounce_en = 1'b0;
    checks++; if (obs_q.size() !== 0) begin fails++; $display("FAIL bounce_events got %0d exp 0", obs_q.size()); end
    checks++; if (changes < 20) begin fails++; $display("FAIL bounce_scanning got %0d changes exp >=20", changes); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_minus();
    obs_q.delete();
    press_mask = 16'h1 << 7;
    repeat (120) @(negedge clk);
    checks++; if (obs_q.size() !== 1) begin fails++; $display("FAIL minus_count got %0d exp 1", obs_q.size()); end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== 5'd12) begin fails++; $display("FAIL minus_event got %0d exp 12", obs_q[0]); end
    checks++; if (bcd !== 4'd5) begin fails++; $display("FAIL minus_bcd got %h exp 5", bcd); end
    press_mask = 16'h0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_two_keys_unused();
    int changes;
    int t;
    logic [3:0] prev;
    obs_q.delete();
    press_mask = (16'h1 << 0) | (16'h1 << 2);
    changes = 0;
    prev = row;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (row !== prev) changes++;
      prev = row;
    end
    checks++; if (obs_q.size() !== 0) begin fails++; $display("FAIL twokey_events got %0d exp 0", obs_q.size()); end
    checks++; if (changes < 20) begin fails++; $display("FAIL twokey_scanning got %0d changes exp >=20", changes); end
    press_mask = 16'h1 << 15;
    repeat (60) @(negedge clk);
    changes = 0;
    prev = row;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (row !== prev) changes++;
      prev = row;
    end
    checks++; if (changes !== 0) begin fails++; $display("FAIL unused_frozen got %0d changes exp 0", changes); end
    checks++; if (row !== 4'b0111) begin fails++; $display("FAIL unused_row got %b exp 0111", row); end
    checks++; if (obs_q.size() !== 0) begin fails++; $display("FAIL unused_events got %0d exp 0", obs_q.size()); end
    press_mask = 16'h0;
    t = 0;
    while (row === 4'b0111 && t < 40) begin @(negedge clk); t++; end
    checks++; if (row !== 4'b1110) begin fails++; $display("FAIL unused_resume got %b exp 1110 after %0d cycles", row, t); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_held();
    int t;
    obs_q.delete();
    press_mask = 16'h1 << 10;
    t = 0;
    while (obs_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
    checks++; if (t >= 200) begin fails++; $display("FAIL held9_timeout no event after %0d cycles", t); end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== 5'd9) begin fails++; $display("FAIL held9_event got %0d exp 9", obs_q[0]); end
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (row !== 4'b1110) begin fails++; $display("FAIL heldrst_row got %b exp 1110", row); end
    checks++; if (bcd !== 4'd0) begin fails++; $display("FAIL heldrst_bcd got %h exp 0", bcd); end
    checks++; if ({dv, ent, pls, mns, eqs, clr} !== 6'b0) begin
      fails++; $display("FAIL heldrst_pulses got %b exp 000000", {dv, ent, pls, mns, eqs, clr});
    end
    press_mask = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    obs_q.delete();
    press_mask = 16'h1 << 13;
    repeat (150) @(negedge clk);
    checks++; if (obs_q.size() !== 1) begin fails++; $display("FAIL zero_count got %0d exp 1", obs_q.size()); end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== 5'd0) begin fails++; $display("FAIL zero_event got %0d exp 0", obs_q[0]); end
    checks++; if (bcd !== 4'd0) begin fails++; $display("FAIL zero_bcd got %h exp 0", bcd); end
    press_mask = 16'h0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random();
    int idx, other, hold, gap;
    logic [3:0] exp_bcd;
    exp_bcd = bcd;
    obs_q.delete();
    exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      idx  = $urandom_range(0, 14);
      hold = $urandom_range(70, 120);
      gap  = $urandom_range(30, 60);
      exp_q.push_back(5'(key_map[idx]));
      if (key_map[idx] < 10) exp_bcd = 4'(key_map[idx]);
      press_mask = 16'h1 << idx;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        // A second key arriving after acceptance must be ignored.
        if (k == 45 && $urandom_range(0, 1) == 1) begin
          other = (idx + 1 + $urandom_range(0, 13)) % 16;
          press_mask = press_mask | (16'h1 << other);
        end
      end
      press_mask = 16'h0;
      repeat (gap) @(negedge clk);
    end
    checks++; if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL random_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL random_event %0d got %0d exp %0d", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (bcd !== exp_bcd) begin fails++; $display("FAIL random_bcd got %h exp %h", bcd, exp_bcd); end
    checks++; if (overlap_cnt !== 0) begin fails++; $display("FAIL pulse_overlap got %0d cycles exp 0", overlap_cnt); end
    checks++; if (bcd_bad_cnt !== 0) begin fails++; $display("FAIL bcd_range got %0d cycles above 9 exp 0", bcd_bad_cnt); end
  endtask

  initial begin
    test_reset();
    test_press_5();
    test_bounce_8();
    test_minus();
    test_two_keys_unused();
    test_reset_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
